// File: rtl/posit_to_float_es3_pkg.sv
// Shared constants, float field layout and regime helper for the es=3 posit-to-binary32 path.
package posit_to_float_es3_pkg;

  localparam int NBITS         = 32;
  localparam int ES            = 3;
  localparam int FRAC_W        = NBITS - ES - 3;
  localparam int FLT_BIAS      = 127;
  localparam int FLT_EXP_BITS  = 8;
  localparam int FLT_MANT_BITS = 23;
  localparam logic [31:0] FLT_QNAN = 32'h7FC00000;

  typedef struct packed {
    logic                     sign;
    logic [FLT_EXP_BITS-1:0]  exp;
    logic [FLT_MANT_BITS-1:0] mant;
  } float_fields;

  // Length of the run of identical leading bits of a posit magnitude (regime run).
  function automatic logic [5:0] regime_run(input logic [NBITS-2:0] v);
    logic [5:0] n;
    logic       stop;
    n    = '0;
    stop = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!stop && (v[i] == v[NBITS-2])) n = n + 6'd1;
      else stop = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/posit_to_float_es3_if.sv
// Start/done streaming bundle between the posit datapath and the float converter.
interface posit_to_float_es3_if;
  import posit_to_float_es3_pkg::*;

  logic [NBITS-1:0] in1;
  logic             start;
  logic [NBITS-1:0] result;
  logic             inf;
  logic             zero;
  logic             done;

  modport master (output in1, start, input result, inf, zero, done);
  modport slave  (input in1, start, output result, inf, zero, done);

endinterface

// File: rtl/posit_to_float_es3_round.sv
// Round-to-nearest-even on a binary32 mantissa; carries into the exponent and flags overflow.
module float_round_rne
  import posit_to_float_es3_pkg::*;
(
  input  logic [FLT_MANT_BITS-1:0] i_mant,
  input  logic                     i_guard,
  input  logic                     i_sticky,
  input  logic [FLT_EXP_BITS-1:0]  i_exp,
  output logic [FLT_MANT_BITS-1:0] o_mant,
  output logic [FLT_EXP_BITS-1:0]  o_exp,
  output logic                     o_ovf
);

  function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  logic [FLT_MANT_BITS:0] w_sum;
  logic [FLT_EXP_BITS:0]  w_exp_sum;

  // A subnormal (exp 0) that carries lands on exp 1 / mantissa 0, the smallest normal.
  always_comb begin
    w_sum     = {1'b0, i_mant} + {{FLT_MANT_BITS{1'b0}}, rne_inc(i_mant[0], i_guard, i_sticky)};
    w_exp_sum = {1'b0, i_exp} + {{FLT_EXP_BITS{1'b0}}, w_sum[FLT_MANT_BITS]};
    o_mant    = w_sum[FLT_MANT_BITS-1:0];
    o_exp     = w_exp_sum[FLT_EXP_BITS-1:0];
    o_ovf     = (w_exp_sum >= 9'd255);
  end

endmodule

// File: rtl/posit_to_float_es3.sv
// 32-bit posit (es=3) to IEEE-754 binary32 converter, fixed 3-cycle start-to-done latency.
module posit_to_float_es3
  import posit_to_float_es3_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  posit_to_float_es3_if.slave bus
);

  logic [NBITS-1:0] r_in_p0;
  logic             r_vld_p0;

  always_ff @(posedge clk) begin
    if (reset) r_vld_p0 <= 1'b0;
    else       r_vld_p0 <= bus.start;
    r_in_p0 <= bus.in1;
  end

  // ---- stage 0: regime / exponent / fraction decode ----
  logic              w_sign_p0;
  logic [NBITS-2:0]  w_mag_p0;
  logic [5:0]        w_run_p0;
  logic [5:0]        w_rlen_p0;
  logic signed [5:0] w_k_p0;
  logic [NBITS-2:0]  w_rem_p0;
  logic [2:0]        w_e_p0;
  logic [FRAC_W-1:0] w_frac_p0;
  logic signed [8:0] w_scale_p0;
  logic              w_nar_p0;
  logic              w_zero_p0;
  logic              w_unused_p0;

  always_comb begin
    w_sign_p0   = r_in_p0[NBITS-1];
    w_mag_p0    = w_sign_p0 ? (~r_in_p0[NBITS-2:0] + 31'd1) : r_in_p0[NBITS-2:0];
    w_run_p0    = regime_run(w_mag_p0);
    w_k_p0      = w_mag_p0[NBITS-2] ? $signed(w_run_p0 - 6'd1) : $signed(6'd0 - w_run_p0);
    // An all-ones magnitude has no terminating bit, so the regime can consume every bit.
    w_rlen_p0   = (w_run_p0 == 6'd31) ? 6'd31 : (w_run_p0 + 6'd1);
    w_rem_p0    = w_mag_p0 << w_rlen_p0;
    w_e_p0      = w_rem_p0[30:28];
    w_frac_p0   = w_rem_p0[27:2];
    w_scale_p0  = $signed({w_k_p0, 3'b000}) + $signed({6'b000000, w_e_p0});
    w_nar_p0    = (r_in_p0 == 32'h80000000);
    w_zero_p0   = (r_in_p0 == 32'h00000000);
    w_unused_p0 = ^w_rem_p0[1:0];
  end

  logic              r_vld_p1;
  logic              r_sign_p1;
  logic signed [8:0] r_scale_p1;
  logic [FRAC_W-1:0] r_frac_p1;
  logic              r_nar_p1;
  logic              r_zero_p1;

  always_ff @(posedge clk) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= r_vld_p0;
    r_sign_p1  <= w_sign_p0;
    r_scale_p1 <= w_scale_p0;
    r_frac_p1  <= w_frac_p0;
    r_nar_p1   <= w_nar_p0;
    r_zero_p1  <= w_zero_p0;
  end

  // ---- stage 1: classify, denormalise, round ----
  logic signed [9:0]       w_e10_p1;
  logic signed [9:0]       w_shr_p1;
  logic                    w_big_p1;
  logic                    w_sub_p1;
  logic [4:0]              w_sh_p1;
  logic [FRAC_W:0]         w_sig_p1;
  logic [FRAC_W:0]         w_shifted_p1;
  logic [FRAC_W:0]         w_lost_p1;
  logic [FLT_MANT_BITS-1:0] w_mant_p1;
  logic                    w_guard_p1;
  logic                    w_sticky_p1;
  logic [FLT_EXP_BITS-1:0] w_exp_in_p1;
  logic                    w_unused_p1;

  always_comb begin
    w_e10_p1     = $signed({r_scale_p1[8], r_scale_p1}) + 10'sd127;
    w_shr_p1     = 10'sd0 - 10'sd126 - $signed({r_scale_p1[8], r_scale_p1});
    w_big_p1     = (r_scale_p1 > 9'sd127);
    w_sub_p1     = (w_e10_p1 < 10'sd1);
    w_sh_p1      = !w_sub_p1 ? 5'd0 : ((w_shr_p1 > 10'sd27) ? 5'd27 : w_shr_p1[4:0]);
    w_sig_p1     = {1'b1, r_frac_p1};
    w_shifted_p1 = w_sig_p1 >> w_sh_p1;
    w_lost_p1    = w_sig_p1 & ~({(FRAC_W+1){1'b1}} << w_sh_p1);
    w_mant_p1    = w_shifted_p1[25:3];
    w_guard_p1   = w_shifted_p1[2];
    w_sticky_p1  = (|w_shifted_p1[1:0]) | (|w_lost_p1);
    w_exp_in_p1  = w_sub_p1 ? 8'd0 : w_e10_p1[7:0];
    w_unused_p1  = w_shifted_p1[FRAC_W];
  end

  logic [FLT_MANT_BITS-1:0] w_rmant_p1;
  logic [FLT_EXP_BITS-1:0]  w_rexp_p1;
  logic                     w_rovf_p1;

  float_round_rne u_round (
    .i_mant   (w_mant_p1),
    .i_guard  (w_guard_p1),
    .i_sticky (w_sticky_p1),
    .i_exp    (w_exp_in_p1),
    .o_mant   (w_rmant_p1),
    .o_exp    (w_rexp_p1),
    .o_ovf    (w_rovf_p1)
  );

  logic                     r_vld_p2;
  logic                     r_sign_p2;
  logic [FLT_MANT_BITS-1:0] r_mant_p2;
  logic [FLT_EXP_BITS-1:0]  r_exp_p2;
  logic                     r_ovf_p2;
  logic                     r_nar_p2;
  logic                     r_zero_p2;

  always_ff @(posedge clk) begin
    if (reset) r_vld_p2 <= 1'b0;
    else       r_vld_p2 <= r_vld_p1;
    r_sign_p2 <= r_sign_p1;
    r_mant_p2 <= w_rmant_p1;
    r_exp_p2  <= w_rexp_p1;
    r_ovf_p2  <= w_big_p1 | w_rovf_p1;
    r_nar_p2  <= r_nar_p1;
    r_zero_p2 <= r_zero_p1;
  end

  // ---- stage 2: pack specials and register outputs ----
  float_fields w_pack_p2;
  logic        w_inf_p2;
  logic        w_zero_p2;

  always_comb begin
    w_pack_p2.sign = r_sign_p2;
    w_pack_p2.exp  = r_exp_p2;
    w_pack_p2.mant = r_mant_p2;
    w_inf_p2       = 1'b0;
    w_zero_p2      = 1'b0;
    if (r_nar_p2) begin
      w_pack_p2 = FLT_QNAN;
      w_inf_p2  = 1'b1;
    end else if (r_zero_p2) begin
      w_pack_p2 = '0;
      w_zero_p2 = 1'b1;
    end else if (r_ovf_p2) begin
      w_pack_p2.exp  = '1;
      w_pack_p2.mant = '0;
    end
  end

  logic [NBITS-1:0] r_result;
  logic             r_inf;
  logic             r_zero;
  logic             r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_inf    <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= r_vld_p2;
      if (r_vld_p2) begin
        r_result <= w_pack_p2;
        r_inf    <= w_inf_p2;
        r_zero   <= w_zero_p2;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.inf    = r_inf;
  assign bus.zero   = r_zero;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_posit_to_float_es3.sv
// Bench for posit_to_float_es3: directed values, random stream against a numeric model, reset flush.
module tb_posit_to_float_es3;
  import posit_to_float_es3_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  posit_to_float_es3_if bus();

  posit_to_float_es3 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected in-flight conversions: index 0 is the one captured at the latest edge.
  logic        pv[4];
  logic [33:0] pe[4];

  // Numeric model: value = sig * 2^(scale - nf), re-quantised onto the binary32 grid.
  function automatic logic [33:0] ref_p2f(input logic [31:0] p);
    logic   s;
    logic [31:0] m;
    int     idx, run, k, e, nf, scale, base, d, eb;
    longint sig, n, remv, half;
    if (p == 32'h00000000) return {2'b01, 32'h00000000};
    if (p == 32'h80000000) return {2'b10, FLT_QNAN};
    s   = p[31];
    m   = s ? (32'h0 - p) : p;
    run = 0;
    idx = 30;
    while (idx >= 0) begin
      if (m[idx] != m[30]) break;
      run++;
      idx--;
    end
    k = m[30] ? (run - 1) : -run;
    idx--;
    e = 0;
    for (int j = 0; j < 3; j++) begin
      e = e * 2;
      if (idx >= 0) begin
        e = e + int'(m[idx]);
        idx--;
      end
    end
    sig = 1;
    nf  = 0;
    while (idx >= 0) begin
      sig = sig * 2 + longint'(m[idx]);
      nf++;
      idx--;
    end
    scale = 8 * k + e;
    if (scale > 127) return {2'b00, s, 8'hFF, 23'h0};
    base = (scale < -126) ? -126 : scale;
    d    = base - 23 - (scale - nf);
    if (d <= 0) begin
      n    = sig << (-d);
      remv = 0;
      half = 1;
    end else begin
      if (d > 40) d = 40;
      n    = sig >> d;
      remv = sig - (n << d);
      half = longint'(1) << (d - 1);
    end
    if ((remv > half) || ((remv == half) && n[0])) n++;
    eb = base + 127;
    if (n == (longint'(1) << 24)) begin
      n  = n >> 1;
      eb++;
    end
    if (n < (longint'(1) << 23)) eb = 0;
    if (eb >= 255) return {2'b00, s, 8'hFF, 23'h0};
    return {2'b00, s, eb[7:0], n[22:0]};
  endfunction

  function automatic logic [31:0] rnd_posit();
    logic [31:0] v;
    v = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) v = 32'h0 - v;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the expectation pipe, check outputs.
  task automatic step(input string tag, input logic st, input logic rs,
                      input logic [31:0] din, input logic [33:0] ex);
    bus.start = st;
    bus.in1   = din;
    reset     = rs;
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pe[i] = pe[i-1];
    end
    pv[0] = st & ~rs;
    pe[0] = ex;
    if (rs) for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    chk({tag, ":done"}, {31'b0, bus.done}, {31'b0, pv[3]});
    if (rs) begin
      chk({tag, ":rst_result"}, bus.result, 32'h0);
      chk({tag, ":rst_inf"}, {31'b0, bus.inf}, 32'h0);
      chk({tag, ":rst_zero"}, {31'b0, bus.zero}, 32'h0);
    end else if (pv[3]) begin
      chk({tag, ":result"}, bus.result, pe[3][31:0]);
      chk({tag, ":inf"}, {31'b0, bus.inf}, {31'b0, pe[3][33]});
      chk({tag, ":zero"}, {31'b0, bus.zero}, {31'b0, pe[3][32]});
    end
  endtask

  logic [31:0] din_t[18];
  logic [33:0] dex_t[18];
  logic [31:0] v;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pe[i] = '0;
    end
    bus.start = 1'b0;
    bus.in1   = '0;
    reset     = 1'b1;

    din_t[0]  = 32'h40000000; dex_t[0]  = {2'b00, 32'h3F800000};
    din_t[1]  = 32'hC0000000; dex_t[1]  = {2'b00, 32'hBF800000};
    din_t[2]  = 32'h44000000; dex_t[2]  = {2'b00, 32'h40000000};
    din_t[3]  = 32'h80000000; dex_t[3]  = {2'b10, 32'h7FC00000};
    din_t[4]  = 32'h00000000; dex_t[4]  = {2'b01, 32'h00000000};
    din_t[5]  = 32'h7FFFFFFF; dex_t[5]  = {2'b00, 32'h7F800000};
    din_t[6]  = 32'h00000001; dex_t[6]  = {2'b00, 32'h00000000};
    din_t[7]  = 32'h40000004; dex_t[7]  = {2'b00, 32'h3F800000};
    din_t[8]  = 32'h4000000C; dex_t[8]  = {2'b00, 32'h3F800002};
    din_t[9]  = 32'h40000005; dex_t[9]  = {2'b00, 32'h3F800001};
    din_t[10] = 32'h00000B00; dex_t[10] = {2'b00, 32'h00000001};
    din_t[11] = 32'hFFFFF500; dex_t[11] = {2'b00, 32'h80000001};
    din_t[12] = 32'h80000001; dex_t[12] = {2'b00, 32'hFF800000};
    din_t[13] = 32'hFFFFFFFF; dex_t[13] = {2'b00, 32'h80000000};
    din_t[14] = 32'h00004800; dex_t[14] = {2'b00, 32'h00400000};
    din_t[15] = 32'h00005000; dex_t[15] = {2'b00, 32'h00800000};
    din_t[16] = 32'h7FFFB800; dex_t[16] = {2'b00, 32'h7F000000};
    din_t[17] = 32'h7FFFC000; dex_t[17] = {2'b00, 32'h7F800000};

    step("reset", 1'b0, 1'b1, 32'h0, '0);
    step("reset", 1'b0, 1'b1, 32'h0, '0);
    step("idle", 1'b0, 1'b0, 32'h0, '0);

    // Isolated directed conversions: done must be a single pulse at +3.
    for (int i = 0; i < 3; i++) begin
      step("basic", 1'b1, 1'b0, din_t[i], dex_t[i]);
      for (int j = 0; j < 4; j++) step("basic_gap", 1'b0, 1'b0, 32'h0, '0);
    end
    for (int i = 3; i < 18; i++) step("directed", 1'b1, 1'b0, din_t[i], dex_t[i]);
    for (int j = 0; j < 4; j++) step("drain", 1'b0, 1'b0, 32'h0, '0);

    for (int i = 0; i < 20; i++) begin
      v = rnd_posit();
      step("stream_a", 1'b1, 1'b0, v, ref_p2f(v));
    end
    step("stream_gap", 1'b0, 1'b0, 32'h0, '0);
    step("stream_gap", 1'b0, 1'b0, 32'h0, '0);
    for (int i = 0; i < 5; i++) begin
      v = rnd_posit();
      step("stream_b", 1'b1, 1'b0, v, ref_p2f(v));
    end
    for (int j = 0; j < 4; j++) step("drain", 1'b0, 1'b0, 32'h0, '0);

    // Three conversions in flight when reset hits; none may emerge.
    for (int i = 0; i < 3; i++) begin
      v = rnd_posit();
      step("inflight", 1'b1, 1'b0, v, ref_p2f(v));
    end
    step("mid_reset", 1'b0, 1'b1, 32'h0, '0);
    for (int j = 0; j < 4; j++) step("post_reset", 1'b0, 1'b0, 32'h0, '0);

    step("start_in_reset", 1'b1, 1'b1, 32'h40000000, {2'b00, 32'h3F800000});
    for (int j = 0; j < 4; j++) step("post_reset", 1'b0, 1'b0, 32'h0, '0);

    step("after_reset", 1'b1, 1'b0, 32'h40000000, {2'b00, 32'h3F800000});
    for (int j = 0; j < 4; j++) step("after_reset_gap", 1'b0, 1'b0, 32'h0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
